// File: rtl/gddr6_cmd_arb_if.sv
// Command/packet types and the bus bundle between the GDDR6 init FSM,
// the runtime command source and the arbiter.
package gddr6_cmd_arb_pkg;
  typedef enum logic [3:0] {
    NOP1  = 4'd0,
    CONF  = 4'd1,
    MRS   = 4'd2,
    REFAB = 4'd3,
    ACT   = 4'd4,
    RD    = 4'd5,
    WR    = 4'd6,
    PREAB = 4'd7
  } cmd_t;

  typedef struct packed {
    logic [3:0]  bk_addr;
    logic [15:0] row_addr;
  } pkt_t;
endpackage

interface gddr6_cmd_arb_if;
  import gddr6_cmd_arb_pkg::*;

  logic init_done;
  pkt_t init_pkt;
  cmd_t init_cmd;
  logic init_pkt_valid;
  logic intf_rdy;
  pkt_t usr_pkt;
  cmd_t usr_cmd;
  logic usr_valid;
  logic usr_rdy;
  pkt_t cmd_out_pkt;
  cmd_t cmd_out_cmd;
  logic cmd_out_valid;
  logic ref_busy;
  logic proto_err;

  modport slave (
    input  init_done, init_pkt, init_cmd, init_pkt_valid, usr_pkt, usr_cmd, usr_valid,
    output intf_rdy, usr_rdy, cmd_out_pkt, cmd_out_cmd, cmd_out_valid, ref_busy, proto_err
  );

  modport master (
    output init_done, init_pkt, init_cmd, init_pkt_valid, usr_pkt, usr_cmd, usr_valid,
    input  intf_rdy, usr_rdy, cmd_out_pkt, cmd_out_cmd, cmd_out_valid, ref_busy, proto_err
  );
endinterface

// File: rtl/gddr6_cmd_arb.sv
// GDDR6 command-issue arbiter: paces init commands, then muxes runtime
// commands with periodic all-bank refresh toward the PHY CA encoder.
module gddr6_cmd_arb
  import gddr6_cmd_arb_pkg::*;
#(
  parameter int unsigned CMD_GAP = 2,
  parameter int unsigned T_REFI  = 1900,
  parameter int unsigned T_RFC   = 120
) (
  input logic             clk,
  input logic             rst_n,
  gddr6_cmd_arb_if.slave  bus
);

  localparam int unsigned CNT_W = 16;

  if (T_REFI <= T_RFC + CMD_GAP) begin : g_bad_refi
    $error("gddr6_cmd_arb: T_REFI must exceed T_RFC + CMD_GAP");
  end
  if (CMD_GAP < 1 || CMD_GAP > 15) begin : g_bad_gap
    $error("gddr6_cmd_arb: CMD_GAP must be in 1..15");
  end

  typedef enum logic [1:0] {INIT, RUN, REF_PEND, REF_HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] gap_cnt, gap_nxt;
  logic [CNT_W-1:0] refi_cnt, refi_nxt;
  logic [CNT_W-1:0] rfc_cnt, rfc_nxt;
  logic             vld_nxt, busy_nxt, perr_nxt;
  cmd_t             cmd_nxt;
  pkt_t             pkt_nxt;
  logic             usr_rdy_int;

  assign usr_rdy_int  = (state == RUN) && (gap_cnt == '0);
  assign bus.usr_rdy  = usr_rdy_int;
  assign bus.intf_rdy = (state == INIT) && (gap_cnt == '0);

  // State, counters and the registered command stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= INIT;
      gap_cnt           <= CNT_W'(1);
      refi_cnt          <= '0;
      rfc_cnt           <= '0;
      bus.cmd_out_valid <= 1'b0;
      bus.cmd_out_cmd   <= NOP1;
      bus.cmd_out_pkt   <= '0;
      bus.ref_busy      <= 1'b0;
      bus.proto_err     <= 1'b0;
    end else begin
      state             <= state_nxt;
      gap_cnt           <= gap_nxt;
      refi_cnt          <= refi_nxt;
      rfc_cnt           <= rfc_nxt;
      bus.cmd_out_valid <= vld_nxt;
      bus.cmd_out_cmd   <= cmd_nxt;
      bus.cmd_out_pkt   <= pkt_nxt;
      bus.ref_busy      <= busy_nxt;
      bus.proto_err     <= perr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gap_nxt   = (gap_cnt == '0) ? '0 : gap_cnt - CNT_W'(1);
    refi_nxt  = refi_cnt;
    rfc_nxt   = rfc_cnt;
    vld_nxt   = 1'b0;
    cmd_nxt   = NOP1;
    pkt_nxt   = '0;
    perr_nxt  = bus.proto_err;

    case (state)
      INIT: begin
        if (bus.init_pkt_valid) begin
          // CONF is a level command and bypasses gap pacing
          if (bus.init_cmd == CONF) begin
            vld_nxt = 1'b1;
            cmd_nxt = bus.init_cmd;
            pkt_nxt = bus.init_pkt;
          end else if (gap_cnt == '0) begin
            vld_nxt = 1'b1;
            cmd_nxt = bus.init_cmd;
            pkt_nxt = bus.init_pkt;
            gap_nxt = CNT_W'(CMD_GAP);
          end else begin
            perr_nxt = 1'b1;
          end
        end
        if (bus.init_done) begin
          state_nxt = RUN;
          refi_nxt  = CNT_W'(T_REFI);
        end
      end
      RUN: begin
        refi_nxt = (refi_cnt == '0) ? '0 : refi_cnt - CNT_W'(1);
        if (refi_cnt == CNT_W'(1)) state_nxt = REF_PEND;
        if (bus.usr_valid && usr_rdy_int) begin
          vld_nxt = 1'b1;
          cmd_nxt = bus.usr_cmd;
          pkt_nxt = bus.usr_pkt;
          gap_nxt = CNT_W'(CMD_GAP);
        end
      end
      REF_PEND: begin
        if (gap_cnt == '0) begin
          vld_nxt   = 1'b1;
          cmd_nxt   = REFAB;
          rfc_nxt   = CNT_W'(T_RFC);
          state_nxt = REF_HOLD;
        end
      end
      REF_HOLD: begin
        rfc_nxt = (rfc_cnt == '0) ? '0 : rfc_cnt - CNT_W'(1);
        if (rfc_cnt == CNT_W'(1)) begin
          state_nxt = RUN;
          refi_nxt  = CNT_W'(T_REFI);
          gap_nxt   = '0;
        end
      end
      default: state_nxt = INIT;
    endcase

    // Leaving init mode: any init traffic is a violation; init_done loss aborts to INIT
    if (state != INIT) begin
      if (bus.init_pkt_valid) perr_nxt = 1'b1;
      if (!bus.init_done) begin
        state_nxt = INIT;
        refi_nxt  = '0;
        rfc_nxt   = '0;
      end
    end

    busy_nxt = (state_nxt == REF_PEND) || (state_nxt == REF_HOLD);
  end

endmodule

// File: tb/tb_gddr6_cmd_arb.sv
// Directed bench for gddr6_cmd_arb: init pacing table, CONF level run,
// refresh timeline with a held user source, and reset during tRFC hold.
module tb_gddr6_cmd_arb;
  import gddr6_cmd_arb_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  gddr6_cmd_arb_if bus ();

  gddr6_cmd_arb #(.CMD_GAP(2), .T_REFI(20), .T_RFC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       ipv;
    cmd_t       icmd;
    logic [3:0] bk;
    logic       exp_rdy;
    logic       exp_vld;
    cmd_t       exp_cmd;
    logic [3:0] exp_bk;
    logic       exp_perr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vld"},   32'(bus.cmd_out_valid), 32'd0);
    chk({tag, "_cmd"},   32'(bus.cmd_out_cmd),   32'(NOP1));
    chk({tag, "_pkt"},   32'(bus.cmd_out_pkt),   32'd0);
    chk({tag, "_busy"},  32'(bus.ref_busy),      32'd0);
    chk({tag, "_perr"},  32'(bus.proto_err),     32'd0);
    chk({tag, "_irdy"},  32'(bus.intf_rdy),      32'd0);
    chk({tag, "_urdy"},  32'(bus.usr_rdy),       32'd0);
  endtask

  initial begin
    logic exp_user;
    logic hs;
    logic found;
    int   sent;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.init_done      = 1'b0;
    bus.init_pkt       = '0;
    bus.init_cmd       = NOP1;
    bus.init_pkt_valid = 1'b0;
    bus.usr_pkt        = '0;
    bus.usr_cmd        = NOP1;
    bus.usr_valid      = 1'b0;

    //            ipv   icmd   bk     rdy   vld   exp_cmd exp_bk perr
    vecs[0] = '{1'b1, MRS,   4'hA, 1'b1, 1'b1, MRS,   4'hA, 1'b0};
    vecs[1] = '{1'b0, NOP1,  4'h0, 1'b0, 1'b0, NOP1,  4'h0, 1'b0};
    vecs[2] = '{1'b1, MRS,   4'h5, 1'b0, 1'b0, NOP1,  4'h0, 1'b1};
    vecs[3] = '{1'b0, NOP1,  4'h0, 1'b1, 1'b0, NOP1,  4'h0, 1'b1};
    vecs[4] = '{1'b1, REFAB, 4'h0, 1'b1, 1'b1, REFAB, 4'h0, 1'b1};
    vecs[5] = '{1'b1, CONF,  4'h3, 1'b0, 1'b1, CONF,  4'h3, 1'b1};
    vecs[6] = '{1'b1, CONF,  4'h7, 1'b0, 1'b1, CONF,  4'h7, 1'b1};
    vecs[7] = '{1'b0, NOP1,  4'h0, 1'b1, 1'b0, NOP1,  4'h0, 1'b1};

    repeat (3) @(negedge clk);
    #1 chk_reset_vals("rst");

    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_irdy_low", 32'(bus.intf_rdy), 32'd0);

    // Init pacing table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.init_pkt_valid     = vecs[i].ipv;
      bus.init_cmd           = vecs[i].icmd;
      bus.init_pkt.bk_addr   = vecs[i].bk;
      bus.init_pkt.row_addr  = 16'(i);
      #1 chk($sformatf("v%0d_irdy", i), 32'(bus.intf_rdy), 32'(vecs[i].exp_rdy));
      chk($sformatf("v%0d_urdy", i), 32'(bus.usr_rdy), 32'd0);
      @(posedge clk);
      #1 chk($sformatf("v%0d_vld", i), 32'(bus.cmd_out_valid), 32'(vecs[i].exp_vld));
      chk($sformatf("v%0d_cmd", i), 32'(bus.cmd_out_cmd), 32'(vecs[i].exp_cmd));
      chk($sformatf("v%0d_bk", i), 32'(bus.cmd_out_pkt.bk_addr), 32'(vecs[i].exp_bk));
      chk($sformatf("v%0d_perr", i), 32'(bus.proto_err), 32'(vecs[i].exp_perr));
    end

    // CONF held for 50 cycles
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bus.init_pkt_valid    = 1'b1;
      bus.init_cmd          = CONF;
      bus.init_pkt.bk_addr  = 4'h6;
      bus.init_pkt.row_addr = 16'(100 + i);
      @(posedge clk);
      #1 chk($sformatf("conf%0d_vld", i), 32'(bus.cmd_out_valid), 32'd1);
      chk($sformatf("conf%0d_row", i), 32'(bus.cmd_out_pkt.row_addr), 32'(100 + i));
    end
    @(negedge clk);
    bus.init_pkt_valid = 1'b0;
    bus.init_cmd       = NOP1;
    bus.init_pkt       = '0;
    @(posedge clk);
    #1 chk("conf_end_vld", 32'(bus.cmd_out_valid), 32'd0);
    chk("conf_end_cmd", 32'(bus.cmd_out_cmd), 32'(NOP1));
    chk("conf_end_perr", 32'(bus.proto_err), 32'd1);

    // Run phase with user source held valid; edge 0 takes init_done
    @(negedge clk);
    bus.init_done = 1'b1;
    bus.usr_valid = 1'b1;
    bus.usr_cmd   = RD;
    bus.usr_pkt   = '{bk_addr: 4'h2, row_addr: 16'd0};
    #1 chk("run0_urdy", 32'(bus.usr_rdy), 32'd0);
    @(posedge clk);
    sent = 0;
    for (int k = 1; k <= 32; k++) begin
      exp_user = ((k <= 19) && ((k % 3) == 1)) || (k == 31);
      @(negedge clk);
      #1 chk($sformatf("run%0d_urdy", k), 32'(bus.usr_rdy), 32'(exp_user));
      hs = bus.usr_rdy && bus.usr_valid;
      @(posedge clk);
      #1;
      if (exp_user) begin
        chk($sformatf("run%0d_ucmd", k), 32'(bus.cmd_out_cmd), 32'(RD));
        chk($sformatf("run%0d_urow", k), 32'(bus.cmd_out_pkt.row_addr), 32'(sent));
      end else if (k == 22) begin
        chk("run22_refab", 32'(bus.cmd_out_cmd), 32'(REFAB));
        chk("run22_refpkt", 32'(bus.cmd_out_pkt), 32'd0);
      end else begin
        chk($sformatf("run%0d_idle", k), 32'(bus.cmd_out_cmd), 32'(NOP1));
      end
      chk($sformatf("run%0d_vld", k), 32'(bus.cmd_out_valid), 32'(exp_user || (k == 22)));
      chk($sformatf("run%0d_busy", k), 32'(bus.ref_busy), 32'((k >= 20) && (k <= 29)));
      if (hs) begin
        sent++;
        bus.usr_pkt.row_addr = 16'(sent);
      end
    end
    chk("run_accepted", 32'(sent), 32'd8);

    // Next refresh, then async reset in the middle of the tRFC hold
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1 found = bus.cmd_out_valid && (bus.cmd_out_cmd == REFAB);
    end
    chk("refab2_seen", 32'(found), 32'd1);
    repeat (2) @(negedge clk);
    #1 chk("hold_busy", 32'(bus.ref_busy), 32'd1);
    rst_n = 1'b0;
    #1 chk_reset_vals("hold_rst");
    bus.init_done = 1'b0;
    bus.usr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel2_irdy", 32'(bus.intf_rdy), 32'd0);
    @(posedge clk);
    #1 chk("rel2_irdy_up", 32'(bus.intf_rdy), 32'd1);
    chk("rel2_urdy", 32'(bus.usr_rdy), 32'd0);

    // Init command while in RUN flags a violation; init_done loss returns to INIT
    @(negedge clk);
    bus.init_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.init_pkt_valid = 1'b1;
    bus.init_cmd       = MRS;
    @(posedge clk);
    #1 chk("run_perr", 32'(bus.proto_err), 32'd1);
    chk("run_init_drop", 32'(bus.cmd_out_valid), 32'd0);
    @(negedge clk);
    bus.init_pkt_valid = 1'b0;
    bus.init_done      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 chk("back_init_irdy", 32'(bus.intf_rdy), 32'd1);
    chk("back_init_urdy", 32'(bus.usr_rdy), 32'd0);
    chk("back_init_perr", 32'(bus.proto_err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gddr6_cmd_arb.md
Name: gddr6_cmd_arb

Overview:
- Command-issue arbiter that sits directly downstream of the GDDR6 initialization FSM.
- Accepts init-sequence commands (CONF, MRS, REFAB) and paces them with intf_rdy.
- After init_done, switches to the runtime command source and inserts periodic all-bank refreshes (REFAB).
- Drives a single registered command/packet stream toward the PHY CA encoder.

Parameters:
CMD_GAP, 2, minimum clk cycles between two issued pulse commands (1..15)
T_REFI, 1900, clk cycles between periodic REFAB commands after init_done
T_RFC, 120, clk cycles after a periodic REFAB during which no command is issued

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
init_done  in  1  initialization complete; level signal
init_pkt  in  pkt_t  init packet (bk_addr/row_addr used for MRS)
init_cmd  in  cmd_t  init command
init_pkt_valid  in  1  init command valid; pulse for MRS/REFAB, level for CONF
intf_rdy  out  1  arbiter can accept an init command
usr_pkt  in  pkt_t  runtime packet
usr_cmd  in  cmd_t  runtime command
usr_valid  in  1  runtime command valid
usr_rdy  out  1  runtime command accepted when usr_valid&&usr_rdy
cmd_out_pkt  out  pkt_t  issued packet
cmd_out_cmd  out  cmd_t  issued command; NOP1 when idle
cmd_out_valid  out  1  issued command valid
ref_busy  out  1  periodic refresh pending or in tRFC hold
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset values:
  - cmd_out_valid=0, cmd_out_cmd=NOP1, cmd_out_pkt=0.
  - ref_busy=0, proto_err=0, intf_rdy=0, usr_rdy=0.
  - state=INIT, gap_cnt=1, refi_cnt=0, rfc_cnt=0.
- All outputs except usr_rdy and intf_rdy are registered.
- usr_rdy and intf_rdy are combinational from state and counters only, never from valid inputs.
- gap_cnt decrements to 0 and saturates there.
- intf_rdy = (state==INIT) && (gap_cnt==0). After reset release it rises one cycle later.
- INIT state:
  - CONF: while init_pkt_valid && init_cmd==CONF, cmd_out_valid=1 with cmd/pkt following the inputs with 1-cycle latency. No gap is applied (level command).
  - On CONF valid falling, cmd_out_valid=0 and cmd_out_cmd=NOP1 next cycle.
  - Non-CONF, init_pkt_valid=1 and gap_cnt==0: register cmd/pkt, cmd_out_valid=1 for exactly one cycle, gap_cnt<=CMD_GAP.
  - Non-CONF, init_pkt_valid=1 and gap_cnt!=0: command dropped, proto_err<=1 (sticky until reset).
  - usr_valid is ignored; usr_rdy=0.
  - init_done high -> RUN, refi_cnt<=T_REFI.
- RUN state:
  - refi_cnt decrements each cycle. At refi_cnt==1 -> REF_PEND (ref_busy=1).
  - usr_rdy = (gap_cnt==0).
  - On handshake: 1-cycle pulse of usr_cmd/usr_pkt on cmd_out, gap_cnt<=CMD_GAP.
- REF_PEND state:
  - usr_rdy=0.
  - When gap_cnt==0: issue REFAB (pkt=0) as a 1-cycle pulse, rfc_cnt<=T_RFC -> REF_HOLD.
- REF_HOLD state:
  - usr_rdy=0, ref_busy=1, rfc_cnt decrements.
  - At rfc_cnt==1 -> RUN, refi_cnt<=T_REFI, gap_cnt<=0.
- Refresh priority: refresh beats a user request in the same cycle. Because usr_rdy is already 0 in REF_PEND, no user command is lost.
- init_done falls in RUN/REF_PEND/REF_HOLD: go to INIT next cycle, clear ref_busy, refi_cnt, rfc_cnt. An already-issued pulse is not retracted.
- init_pkt_valid while state!=INIT: ignored, proto_err<=1.
- rst_n asserted at any time: asynchronous return to reset values, including mid-tRFC hold or mid-CONF.
- Counters are 16-bit unsigned. T_REFI > T_RFC+CMD_GAP is required; check it with an elaboration assertion.

Test Plan:
- Reset release, init_pkt_valid pulses MRS bk_addr=4'hA at first intf_rdy -> intf_rdy=1 at cycle 1; cmd_out MRS pulse 1 cycle later; intf_rdy low for exactly 2 cycles (CMD_GAP=2).
- CONF held valid for 50 cycles -> cmd_out_valid=1 for 50 consecutive cycles starting 1 cycle after valid; then NOP1, valid=0.
- MRS pulse issued while gap_cnt=1 -> no cmd_out pulse, proto_err=1 and stays 1.
- init_done=1, T_REFI=20, T_RFC=8, usr_valid held high -> user pulses every 3 cycles; REFAB issued ~20 cycles after init_done; usr_rdy=0 for 8 cycles after REFAB; no user command dropped or duplicated.
- usr_valid and refresh expiry in the same cycle -> REFAB issued first; user command accepted after tRFC hold.
- Deassert rst_n during REF_HOLD -> all outputs return to reset values immediately; after release state=INIT, usr_rdy=0.
